// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end constants used by the fetch path and its benches.
package riscv_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned INST_W   = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_011C;

endpackage

// File: rtl/ifetch_fifo.sv
// Synchronous FIFO with push/pop/clear; head is always the oldest entry.
module ifetch_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         clear_i,
    input  logic                         push_i,
    input  logic [WIDTH-1:0]             push_data_i,
    input  logic                         pop_i,
    output logic [WIDTH-1:0]             head_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         full_o,
    output logic                         empty_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_o <= '0;
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
        end else if (clear_i) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_o <= '0;
        end else begin
            assert (!(push_i && full_o && !pop_i)) else $error("ifetch_fifo overflow");
            assert (!(pop_i && empty_o)) else $error("ifetch_fifo underflow");
            if (push_i) begin
                mem[wr_ptr] <= push_data_i;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (pop_i) rd_ptr <= next_ptr(rd_ptr);
            unique case ({push_i, pop_i})
                2'b10:   count_o <= count_o + CNT_W'(1);
                2'b01:   count_o <= count_o - CNT_W'(1);
                default: ;
            endcase
        end
    end

    always_comb begin
        head_o  = mem[rd_ptr];
        full_o  = (count_o == CNT_W'(DEPTH));
        empty_o = (count_o == '0);
    end

endmodule

// File: rtl/ifetch_unit.sv
// Fetch front end: credit-limited imem requests, in-order response queue,
// and wrong-path response squashing after a redirect.
module ifetch_unit #(
    parameter int unsigned XLEN    = riscv_pkg::XLEN,
    parameter int unsigned DEPTH   = 2,
    parameter int unsigned MAX_OUT = 2
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic            redirect_i,
    output logic            halt_o,
    output logic            imem_req_valid_o,
    output logic [XLEN-1:0] imem_req_addr_o,
    input  logic            imem_req_ready_i,
    input  logic            imem_rsp_valid_i,
    input  logic [XLEN-1:0] imem_rsp_data_i,
    output logic            inst_valid_o,
    output logic [XLEN-1:0] inst_o,
    output logic [XLEN-1:0] inst_pc_o,
    input  logic            inst_ready_i
);

    localparam int unsigned OUT_W = $clog2(MAX_OUT + 1);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [OUT_W-1:0]  outstanding;
    logic [OUT_W-1:0]  discard;
    logic [OUT_W-1:0]  aq_count;
    logic              aq_full;
    logic              aq_empty;
    logic [XLEN-1:0]   aq_head;
    logic [CNT_W-1:0]  buf_count;
    logic              buf_full;
    logic              buf_empty;
    logic [2*XLEN-1:0] buf_head;
    logic              can_issue;
    logic              fire;
    logic              rsp_live;
    logic              rsp_drop;
    logic              pop;

    // Credit check uses registered occupancy; a pop frees its slot one cycle later.
    always_comb begin
        can_issue = ~reset_i & ~redirect_i
                  & ((32'(outstanding) + 32'(discard)) < MAX_OUT)
                  & ((32'(buf_count) + 32'(outstanding)) < DEPTH);
        fire             = can_issue & imem_req_ready_i;
        rsp_live         = imem_rsp_valid_i & (discard == '0) & ~redirect_i;
        rsp_drop         = imem_rsp_valid_i & (discard != '0);
        inst_valid_o     = ~buf_empty & ~redirect_i & ~reset_i;
        pop              = inst_valid_o & inst_ready_i;
        halt_o           = ~fire;
        imem_req_valid_o = can_issue;
        imem_req_addr_o  = pc_i;
        {inst_o, inst_pc_o} = buf_head;
    end

    // On redirect every live read becomes a read to squash, minus one returning now.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            outstanding <= '0;
            discard     <= '0;
        end else begin
            assert (!(imem_rsp_valid_i && outstanding == '0 && discard == '0))
                else $error("ifetch_unit response with nothing outstanding");
            assert (aq_count == outstanding) else $error("ifetch_unit address queue out of sync");
            assert (!(fire && aq_full && !rsp_live)) else $error("ifetch_unit address queue overflow");
            assert (!(rsp_live && (aq_empty || buf_full))) else $error("ifetch_unit response without slot");
            if (redirect_i) begin
                outstanding <= '0;
                discard     <= discard + outstanding - OUT_W'(imem_rsp_valid_i);
            end else begin
                outstanding <= outstanding + OUT_W'(fire) - OUT_W'(rsp_live);
                discard     <= discard - OUT_W'(rsp_drop);
            end
        end
    end

    ifetch_fifo #(.WIDTH(XLEN), .DEPTH(MAX_OUT)) u_addr_q (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .clear_i     (redirect_i),
        .push_i      (fire),
        .push_data_i (pc_i),
        .pop_i       (rsp_live),
        .head_o      (aq_head),
        .count_o     (aq_count),
        .full_o      (aq_full),
        .empty_o     (aq_empty)
    );

    ifetch_fifo #(.WIDTH(2*XLEN), .DEPTH(DEPTH)) u_inst_buf (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .clear_i     (redirect_i),
        .push_i      (rsp_live),
        .push_data_i ({imem_rsp_data_i, aq_head}),
        .pop_i       (pop),
        .head_o      (buf_head),
        .count_o     (buf_count),
        .full_o      (buf_full),
        .empty_o     (buf_empty)
    );

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: drives a PC register and an in-order imem, and checks
// the fetch unit against a queue-based model of in-flight reads and the buffer.
module tb_ifetch_unit;
    import riscv_pkg::*;

    localparam int DEPTH   = 2;
    localparam int MAX_OUT = 2;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic [31:0] pc_i;
    logic        redirect_i;
    logic        halt_o;
    logic        imem_req_valid_o;
    logic [31:0] imem_req_addr_o;
    logic        imem_req_ready_i;
    logic        imem_rsp_valid_i;
    logic [31:0] imem_rsp_data_i;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        inst_ready_i;

    ifetch_unit #(.XLEN(32), .DEPTH(DEPTH), .MAX_OUT(MAX_OUT)) dut (
        .clk_i            (clk_i),
        .reset_i          (reset_i),
        .pc_i             (pc_i),
        .redirect_i       (redirect_i),
        .halt_o           (halt_o),
        .imem_req_valid_o (imem_req_valid_o),
        .imem_req_addr_o  (imem_req_addr_o),
        .imem_req_ready_i (imem_req_ready_i),
        .imem_rsp_valid_i (imem_rsp_valid_i),
        .imem_rsp_data_i  (imem_rsp_data_i),
        .inst_valid_o     (inst_valid_o),
        .inst_o           (inst_o),
        .inst_pc_o        (inst_pc_o),
        .inst_ready_i     (inst_ready_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct { logic [31:0] addr; bit live; int due; } req_t;
    typedef struct { logic [31:0] pc; logic [31:0] word; } ent_t;

    req_t        inflight[$];
    ent_t        ibuf[$];
    logic [31:0] delivered[$];
    logic [31:0] delivered_w[$];
    logic [31:0] pc;
    logic [31:0] target;
    int          cyc;
    int          lat;
    int          issued;
    int          checks;
    int          errors;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a << 4) ^ 32'h0000_0013;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic drive_env();
        pc_i             = pc;
        imem_rsp_valid_i = (inflight.size() != 0) && (inflight[0].due <= cyc);
        imem_rsp_data_i  = imem_rsp_valid_i ? mem_word(inflight[0].addr) : 32'h0;
    endtask

    // One clock: compare at negedge, then advance PC, imem and model past the edge.
    task automatic step();
        logic r, red, rsp, rdy, dec, exp_req, exp_iv;
        int   live_cnt;
        int   due;
        req_t rq;
        @(negedge clk_i);
        r = reset_i; red = redirect_i; rsp = imem_rsp_valid_i;
        rdy = imem_req_ready_i; dec = inst_ready_i;
        live_cnt = 0;
        foreach (inflight[i]) if (inflight[i].live) live_cnt++;
        exp_req = !red && (inflight.size() < MAX_OUT) && (ibuf.size() + live_cnt < DEPTH);
        exp_iv  = (ibuf.size() != 0) && !red;
        if (!r) begin
            chk("req_valid", 32'(imem_req_valid_o), 32'(exp_req));
            chk("halt", 32'(halt_o), 32'(!(exp_req && rdy)));
            if (exp_req) chk("req_addr", imem_req_addr_o, pc);
            chk("inst_valid", 32'(inst_valid_o), 32'(exp_iv));
            if (exp_iv) begin
                chk("inst_pc", inst_pc_o, ibuf[0].pc);
                chk("inst", inst_o, ibuf[0].word);
            end
        end
        @(posedge clk_i);
        #1;
        if (r) begin
            inflight.delete();
            ibuf.delete();
            pc = RESET_PC;
        end else begin
            if (exp_iv && dec) begin
                delivered.push_back(ibuf[0].pc);
                delivered_w.push_back(ibuf[0].word);
                void'(ibuf.pop_front());
            end
            if (rsp) begin
                rq = inflight.pop_front();
                if (rq.live && !red) ibuf.push_back('{rq.addr, mem_word(rq.addr)});
            end
            if (red) begin
                ibuf.delete();
                foreach (inflight[i]) inflight[i].live = 1'b0;
                pc = target;
            end else if (exp_req && rdy) begin
                due = cyc + lat;
                if (inflight.size() != 0 && due <= inflight[$].due) due = inflight[$].due + 1;
                inflight.push_back('{pc, 1'b1, due});
                issued++;
                pc = pc + 32'd4;
            end
        end
        cyc++;
        drive_env();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        reset_i    = 1'b1;
        redirect_i = 1'b0;
        run(2);
        reset_i = 1'b0;
        delivered.delete();
        delivered_w.delete();
        issued = 0;
    endtask

    task automatic redirect_to(input logic [31:0] t);
        redirect_i = 1'b1;
        target     = t;
        step();
        redirect_i = 1'b0;
    endtask

    task automatic wait_deliver(input int budget);
        int k = 0;
        while (delivered.size() == 0 && k < budget) begin
            step();
            k++;
        end
        checks++;
        if (delivered.size() == 0) begin
            errors++;
            $display("FAIL deliver_timeout: no instruction after %0d cycles, expected one", budget);
        end
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0; lat = 1; issued = 0;
        pc = RESET_PC; target = 32'h0;
        reset_i = 1'b1; redirect_i = 1'b0;
        inst_ready_i = 1'b1; imem_req_ready_i = 1'b1;
        drive_env();

        // Reset outputs
        step();
        #1;
        chk("rst_halt", 32'(halt_o), 32'd1);
        chk("rst_req_valid", 32'(imem_req_valid_o), 32'd0);
        chk("rst_inst_valid", 32'(inst_valid_o), 32'd0);
        chk("rst_inst", inst_o, 32'h0);
        chk("rst_inst_pc", inst_pc_o, 32'h0);
        do_reset();

        // Streaming with 1-cycle imem
        run(20);
        if (delivered.size() < 4) chk("stream_count", 32'(delivered.size()), 32'd4);
        else begin
            chk("stream_pc0", delivered[0], 32'h0000_011C);
            chk("stream_pc1", delivered[1], 32'h0000_0120);
            chk("stream_pc2", delivered[2], 32'h0000_0124);
            chk("stream_pc3", delivered[3], 32'h0000_0128);
            chk("stream_word0", delivered_w[0], 32'h0000_11D3);
        end

        // Decode backpressure: buffer fills, no further reads, then reset while full
        do_reset();
        inst_ready_i = 1'b0;
        run(10);
        #1;
        chk("bp_issued", 32'(issued), 32'd2);
        chk("bp_halt", 32'(halt_o), 32'd1);
        chk("bp_head", inst_pc_o, 32'h0000_011C);
        chk("bp_valid", 32'(inst_valid_o), 32'd1);
        reset_i = 1'b1;
        step();
        #1;
        chk("rstfull_valid", 32'(inst_valid_o), 32'd0);
        chk("rstfull_halt", 32'(halt_o), 32'd1);
        step();
        reset_i = 1'b0; inst_ready_i = 1'b1;
        delivered.delete(); delivered_w.delete();
        wait_deliver(20);
        if (delivered.size() != 0) chk("rstfull_first", delivered[0], 32'h0000_011C);

        // Redirect with two reads in flight (latency 3)
        do_reset();
        lat = 3;
        run(2);
        redirect_to(32'h0000_0200);
        wait_deliver(30);
        if (delivered.size() != 0) chk("redir_first", delivered[0], 32'h0000_0200);

        // Reset with two reads outstanding: stale discards must not survive
        do_reset();
        lat = 3;
        run(2);
        reset_i = 1'b1;
        step();
        #1;
        chk("rstout_halt", 32'(halt_o), 32'd1);
        chk("rstout_valid", 32'(inst_valid_o), 32'd0);
        step();
        reset_i = 1'b0;
        delivered.delete(); delivered_w.delete();
        wait_deliver(30);
        if (delivered.size() != 0) chk("rstout_first", delivered[0], 32'h0000_011C);

        // Redirect coincident with a response (latency 2)
        do_reset();
        lat = 2;
        run(2);
        chk("coinc_rsp", 32'(imem_rsp_valid_i), 32'd1);
        redirect_to(32'h0000_0300);
        wait_deliver(30);
        if (delivered.size() != 0) begin
            chk("coinc_first", delivered[0], 32'h0000_0300);
            chk("coinc_word", delivered_w[0], 32'h0000_3013);
        end

        // imem not ready for 5 cycles
        do_reset();
        lat = 1;
        run(6);
        imem_req_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            #1;
            chk("stall_halt", 32'(halt_o), 32'd1);
        end
        imem_req_ready_i = 1'b1;
        run(12);
        if (delivered.size() > 0) chk("stall_first", delivered[0], 32'h0000_011C);
        chk("stall_seq_len", 32'(delivered.size() > 5), 32'd1);
        for (int i = 1; i < delivered.size(); i++)
            chk("stall_seq", delivered[i], delivered[i-1] + 32'd4);

        // Mixed traffic: random stalls, latencies and redirects against the model
        do_reset();
        for (int i = 0; i < 400; i++) begin
            inst_ready_i     = ($urandom_range(0, 3) != 0);
            imem_req_ready_i = ($urandom_range(0, 3) != 0);
            lat              = int'($urandom_range(1, 4));
            if ($urandom_range(0, 15) == 0) redirect_to({20'h0, 10'($urandom_range(0, 1023)), 2'b00});
            else step();
        end
        inst_ready_i = 1'b1; imem_req_ready_i = 1'b1;
        run(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
